// File: rtl/key_event_decoder.sv
// key_event_decoder
//   Classifies a debounced, active-low key into short press, long press with
//   auto-repeat, and double click. Every output is registered; each pulse is
//   high for exactly one cycle, the cycle after the deciding clock edge.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   key_n        debounced key level, 0 = pressed
//   short_pulse  single short press classified
//   long_pulse   hold reached LONG_NUM cycles
//   repeat_pulse every REPEAT_NUM cycles while long-held
//   double_pulse second press inside the DBL_NUM window
//   busy         FSM is not IDLE
//   event_cnt    count of short + long + double events, wraps 255 -> 0
module key_event_decoder #(
  parameter logic [23:0] LONG_NUM   = 24'd12_000_000,
  parameter logic [23:0] DBL_NUM    = 24'd3_600_000,
  parameter logic [23:0] REPEAT_NUM = 24'd2_400_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       double_pulse,
  output logic       busy,
  output logic [7:0] event_cnt
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PRESS1   = 3'd1;
  localparam logic [2:0] LONG     = 3'd2;
  localparam logic [2:0] WAIT2    = 3'd3;
  localparam logic [2:0] WAIT_REL = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        key_n_q;
  logic        short_q, short_d;
  logic        long_q, long_d;
  logic        rep_q, rep_d;
  logic        dbl_q, dbl_d;
  logic        busy_q;
  logic [7:0]  evcnt_q, evcnt_d;
  logic        press;

  // Falling edge of the key level; key_n_q resets to 1 so a key held
  // through reset is seen as a fresh press.
  assign press = key_n_q & ~key_n;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 24'd1;
    short_d = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    dbl_d   = 1'b0;
    evcnt_d = evcnt_q;
    case (state_q)
      IDLE: begin
        if (press) state_d = PRESS1;
      end
      PRESS1: begin
        // Release wins over the long threshold on the same cycle.
        if (key_n) begin
          state_d = WAIT2;
        end else if (cnt_q == LONG_NUM - 24'd1) begin
          long_d  = 1'b1;
          evcnt_d = evcnt_q + 8'd1;
          state_d = LONG;
        end
      end
      LONG: begin
        if (key_n) begin
          state_d = IDLE;
        end else if (cnt_q == REPEAT_NUM - 24'd1) begin
          rep_d = 1'b1;
          cnt_d = '0;
        end
      end
      WAIT2: begin
        // A repress wins over the timeout on the same cycle.
        if (press) begin
          dbl_d   = 1'b1;
          evcnt_d = evcnt_q + 8'd1;
          state_d = WAIT_REL;
        end else if (cnt_q == DBL_NUM - 24'd1) begin
          short_d = 1'b1;
          evcnt_d = evcnt_q + 8'd1;
          state_d = IDLE;
        end
      end
      WAIT_REL: begin
        // Second press of a double click is inert until released.
        if (key_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_n_q <= 1'b1;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      dbl_q   <= 1'b0;
      busy_q  <= 1'b0;
      evcnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_n_q <= key_n;
      short_q <= short_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
      dbl_q   <= dbl_d;
      busy_q  <= (state_d != IDLE);
      evcnt_q <= evcnt_d;
    end
  end

  assign short_pulse  = short_q;
  assign long_pulse   = long_q;
  assign repeat_pulse = rep_q;
  assign double_pulse = dbl_q;
  assign busy         = busy_q;
  assign event_cnt    = evcnt_q;

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Consumes the clean, active-low key level produced by the button debouncer.
- Classifies presses into short press, long press with auto-repeat, and double click.
- Emits a registered single-cycle pulse per event, plus a running event count.
- Sits between the debounce stage and application logic (menus, counters, LED modes).

Parameters:
LONG_NUM, 24'd12_000_000, hold cycles before long press (1 s at 12 MHz)
DBL_NUM, 24'd3_600_000, max release-to-repress gap for double click (300 ms)
REPEAT_NUM, 24'd2_400_000, auto-repeat period while long-held (200 ms)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
key_n  input  1  debounced key level, 0 = pressed, already glitch-free
short_pulse  output  1  one-cycle pulse: single short press classified
long_pulse  output  1  one-cycle pulse: hold reached LONG_NUM
repeat_pulse  output  1  one-cycle pulse every REPEAT_NUM cycles after long
double_pulse  output  1  one-cycle pulse: second press inside DBL_NUM window
busy  output  1  high whenever FSM is not IDLE
event_cnt  output  8  count of short+long+double events (repeats excluded), wraps 255->0

Behaviour:
- Reset:
  - One clock; rst synchronous active-high, sampled on posedge clk.
  - While rst is high: all pulses 0, busy 0, event_cnt 0, state IDLE, cnt 0, key_n_r 1.
- Registers:
  - key_n_r <= key_n every cycle.
  - press = key_n_r & ~key_n.
  - cnt is a 24-bit counter, cleared on every state change.
- All outputs are registered. Each pulse is high for exactly one cycle, the cycle after the deciding edge. busy is registered (state != IDLE).
- FSM. In every state, transitions are checked top to bottom; the first match wins. Otherwise cnt++.
  - IDLE:
    - press -> PRESS1.
  - PRESS1:
    - key_n==1 -> WAIT2. Release has priority over threshold on the same cycle.
    - cnt==LONG_NUM-1 -> long_pulse, event_cnt++, -> LONG.
  - LONG:
    - key_n==1 -> IDLE. No short_pulse.
    - cnt==REPEAT_NUM-1 -> repeat_pulse, cnt<=0, stay.
  - WAIT2:
    - press -> double_pulse, event_cnt++, -> WAIT_REL. Press has priority over timeout.
    - cnt==DBL_NUM-1 -> short_pulse, event_cnt++, -> IDLE.
  - WAIT_REL:
    - key_n==1 -> IDLE.
    - The second press of a double click never yields long or repeat, however long it is held.
- Latency:
  - long_pulse is high exactly LONG_NUM cycles after the press-detect edge.
  - short_pulse is high DBL_NUM cycles after the release edge.
  - double_pulse is high the cycle after the second press-detect edge.
- Key held through reset release: key_n_r resets to 1, so a pressed key is detected as a new press on the first cycle after rst falls.
- Simultaneous event_cnt increments cannot occur; at most one classified event per cycle.
- No pulse is ever generated while rst is high, including one pending from the prior cycle.
- Thresholds use == compares only. Parameters must be >= 2.

Test Plan:
Bench parameters: LONG_NUM=20, DBL_NUM=10, REPEAT_NUM=5.
1. Short press: key_n low 5 cycles, then high 15 -> short_pulse once, 10 cycles after release; event_cnt 0->1; no long/double/repeat.
2. Long hold: key_n low 32 cycles then high -> long_pulse 20 cycles after press-detect; repeat_pulse at +5 and +10; no short_pulse after release; event_cnt=1; busy low one cycle after release.
3. Double click: low 3, high 4, low 30, high -> double_pulse one cycle after second press-detect; no short, long or repeat; event_cnt=1; IDLE after release.
4. Boundary release: release exactly at cnt==19 in PRESS1 -> no long_pulse; short_pulse 10 cycles later.
5. Boundary repress: repress at cnt==9 in WAIT2 -> double_pulse; no short_pulse.
6. Reset mid-operation:
   - Assert rst for 2 cycles during LONG with key still low -> outputs 0, event_cnt 0.
   - After rst falls -> new press detected; long_pulse 20 cycles later.
   - Separately, 256 short presses -> event_cnt wraps to 0.
